// File: rtl/fully_pipelined_adder.sv
// fully_pipelined_adder -- bit-level pipelined ripple adder.
//
// Each bit has its own 1-bit full adder stage. The carry is registered
// between stages, so no combinational path crosses more than one full adder.
// Operand bits are skewed on the way in and sum bits are deskewed on the way
// out, so a new operation can enter every cycle and all result bits come out
// together, WIDTH-1 edges after the operands are sampled.
//
// Parameters:
//   WIDTH      operand/sum width, 1..64 (default 4)
// Ports:
//   s          registered sum, (a+b+cin) mod 2^WIDTH
//   c          registered carry-out, bit WIDTH of a+b+cin
//   a, b       unsigned addends, sampled every rising edge
//   cin        carry-in, sampled with a/b
//   clk        clock, rising edge
//   rst        asynchronous active-high reset; clears every pipeline register
//   in_valid   (FULLY_PIPELINED_ADDER_VALID_EN only) tag for the operands
//   out_valid  (FULLY_PIPELINED_ADDER_VALID_EN only) tag aligned with s/c
//
// Build option: define FULLY_PIPELINED_ADDER_VALID_EN to add the in_valid and
// out_valid ports and the valid shift register. The default build has no
// valid logic.

// One bit lane. IDX skew registers delay the operand bits so they meet the
// carry of the same operation. One full-adder stage registers the sum bit and
// the carry. WIDTH-1-IDX deskew registers then align the sum bit with the
// top lane.
module fully_pipelined_adder_lane #(
    parameter int WIDTH = 4,
    parameter int IDX   = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic a_bit,
    input  logic b_bit,
    input  logic ci,
    output logic co,
    output logic s_bit
);
    localparam int DSK = WIDTH - 1 - IDX;

    logic a_q, b_q;
    logic s_r;

    generate
        if (IDX == 0) begin : g_noskew
            assign a_q = a_bit;
            assign b_q = b_bit;
        end else begin : g_skew
            logic [IDX-1:0] a_sr, b_sr;
            logic [IDX:0]   a_ch, b_ch;
            // Element 0 of each chain is the live input bit.
            assign a_ch = {a_sr, a_bit};
            assign b_ch = {b_sr, b_bit};
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_sr <= '0;
                    b_sr <= '0;
                end else begin
                    a_sr <= a_ch[IDX-1:0];
                    b_sr <= b_ch[IDX-1:0];
                end
            end
            assign a_q = a_ch[IDX];
            assign b_q = b_ch[IDX];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_r <= 1'b0;
            co  <= 1'b0;
        end else begin
            s_r <= a_q ^ b_q ^ ci;
            co  <= (a_q & b_q) | (ci & (a_q ^ b_q));
        end
    end

    generate
        if (DSK == 0) begin : g_nodeskew
            assign s_bit = s_r;
        end else begin : g_deskew
            logic [DSK-1:0] d_sr;
            logic [DSK:0]   s_ch;
            assign s_ch = {d_sr, s_r};
            always_ff @(posedge clk or posedge rst) begin
                if (rst) d_sr <= '0;
                else     d_sr <= s_ch[DSK-1:0];
            end
            assign s_bit = s_ch[DSK];
        end
    endgenerate
endmodule

module fully_pipelined_adder #(
    parameter int WIDTH = 4
) (
    output logic [WIDTH-1:0] s,
    output logic             c,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             clk,
    input  logic             rst
`ifdef FULLY_PIPELINED_ADDER_VALID_EN
    ,
    input  logic             in_valid,
    output logic             out_valid
`endif
);
    // cy[i] is the carry into lane i. cy[0] is the live carry-in. Each
    // higher entry is the registered carry-out of the lane below.
    logic [WIDTH:0] cy;
    assign cy[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_lane
            fully_pipelined_adder_lane #(.WIDTH(WIDTH), .IDX(gi)) u_lane (
                .clk   (clk),
                .rst   (rst),
                .a_bit (a[gi]),
                .b_bit (b[gi]),
                .ci    (cy[gi]),
                .co    (cy[gi+1]),
                .s_bit (s[gi])
            );
        end
    endgenerate

    // The top lane's carry register is already aligned with the deskewed sum.
    assign c = cy[WIDTH];

`ifdef FULLY_PIPELINED_ADDER_VALID_EN
    // WIDTH registers deep, which matches the data latency of WIDTH-1 edges
    // after sampling.
    logic [WIDTH-1:0] vld_q;
    logic [WIDTH:0]   vld_pipe;
    assign vld_pipe = {vld_q, in_valid};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_q <= '0;
        else     vld_q <= vld_pipe[WIDTH-1:0];
    end
    assign out_valid = vld_q[WIDTH-1];
`endif
endmodule

// File: tb/tb_fully_pipelined_adder.sv
// Self-checking bench for fully_pipelined_adder.
// Three instances are built: WIDTH 1, 4 and 16. A queue-based model of
// a+b+cin with a WIDTH-1 edge delay predicts every output, and directed
// constants cover the fixed vectors.
module tb_fully_pipelined_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [0:0]  a1, b1, s1;
    logic [3:0]  a4, b4, s4;
    logic [15:0] a16, b16, s16;
    logic cin1, cin4, cin16, c1, c4, c16;
    logic v1, v4, v16, ov1, ov4, ov16;

    int vectors = 0;
    int miscompares = 0;

    // Model: per-instance queues of the exact sums still in flight.
    int q1[$], q4[$], q16[$];
    logic qv4[$];
    int e1, e4, e16;
    logic ev4;

    fully_pipelined_adder #(.WIDTH(1)) dut1 (
        .s(s1), .c(c1), .a(a1), .b(b1), .cin(cin1), .clk(clk), .rst(rst)
`ifdef FULLY_PIPELINED_ADDER_VALID_EN
        , .in_valid(v1), .out_valid(ov1)
`endif
    );
    fully_pipelined_adder #(.WIDTH(4)) dut4 (
        .s(s4), .c(c4), .a(a4), .b(b4), .cin(cin4), .clk(clk), .rst(rst)
`ifdef FULLY_PIPELINED_ADDER_VALID_EN
        , .in_valid(v4), .out_valid(ov4)
`endif
    );
    fully_pipelined_adder #(.WIDTH(16)) dut16 (
        .s(s16), .c(c16), .a(a16), .b(b16), .cin(cin16), .clk(clk), .rst(rst)
`ifdef FULLY_PIPELINED_ADDER_VALID_EN
        , .in_valid(v16), .out_valid(ov16)
`endif
    );

`ifndef FULLY_PIPELINED_ADDER_VALID_EN
    assign ov1 = 1'b0;
    assign ov4 = 1'b0;
    assign ov16 = 1'b0;
`endif

    // Drive one operation, advance one edge, then update the model. The
    // WIDTH-4 operands come from the caller. The other two instances get
    // random operands.
    task automatic cycle(input logic [3:0] xa, input logic [3:0] xb,
                         input logic xc, input logic xv);
        a4 = xa; b4 = xb; cin4 = xc; v4 = xv;
        a1 = 1'($urandom_range(1)); b1 = 1'($urandom_range(1));
        cin1 = 1'($urandom_range(1));
        a16 = 16'($urandom_range(65535)); b16 = 16'($urandom_range(65535));
        cin16 = 1'($urandom_range(1));
        v1 = 1'b0; v16 = 1'b0;
        @(posedge clk); #1;
        q1.push_back(int'(a1) + int'(b1) + int'(cin1));
        q4.push_back(int'(xa) + int'(xb) + int'(xc));
        q16.push_back(int'(a16) + int'(b16) + int'(cin16));
        qv4.push_back(xv);
        // Until a queue holds WIDTH entries, the output still shows
        // reset-cleared registers.
        e1 = (q1.size() == 1) ? q1.pop_front() : 0;
        e4 = (q4.size() == 4) ? q4.pop_front() : 0;
        e16 = (q16.size() == 16) ? q16.pop_front() : 0;
        ev4 = (qv4.size() == 4) ? qv4.pop_front() : 1'b0;
    endtask

    task automatic flush_model();
        q1.delete(); q4.delete(); q16.delete(); qv4.delete();
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if ({c4, s4} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_w4: got c=%b s=%b want c=0 s=0000", c4, s4);
        end
        vectors++;
        if ({c16, s16} !== 17'b0 || {c1, s1} !== 2'b0) begin
            miscompares++;
            $display("FAIL reset_w1_w16: got %b/%h %b/%b want all 0", c16, s16, c1, s1);
        end
`ifdef FULLY_PIPELINED_ADDER_VALID_EN
        vectors++;
        if (ov4 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid: got %b want 0", ov4);
        end
`endif
        rst = 1'b0;
        flush_model();
    endtask

    // 4 + 5 + 1 = 10 -> 1010, no carry, after edge k+3.
    task automatic test_basic();
        cycle(4'd4, 4'd5, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({c4, s4} !== 5'b0) begin
                miscompares++;
                $display("FAIL basic_fill%0d: got c=%b s=%b want 0", i, c4, s4);
            end
            cycle(4'd0, 4'd0, 1'b0, 1'b0);
        end
        vectors++;
        if (s4 !== 4'b1010 || c4 !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_4p5p1: got c=%b s=%b want c=0 s=1010", c4, s4);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] want [3];
        logic       wv [3];
        want[0] = 5'b1_0011; want[1] = 5'b1_0001; want[2] = 5'b0_0000;
        wv[0] = 1'b1; wv[1] = 1'b0; wv[2] = 1'b1;
        cycle(4'd15, 4'd4, 1'b0, 1'b1);
        cycle(4'd8,  4'd8, 1'b1, 1'b0);
        cycle(4'd0,  4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(4'd0, 4'd0, 1'b0, 1'b0);
            vectors++;
            if ({c4, s4} !== want[i]) begin
                miscompares++;
                $display("FAIL b2b_op%0d: got c=%b s=%b want %b", i, c4, s4, want[i]);
            end
`ifdef FULLY_PIPELINED_ADDER_VALID_EN
            vectors++;
            if (ov4 !== wv[i]) begin
                miscompares++;
                $display("FAIL b2b_valid%0d: got %b want %b", i, ov4, wv[i]);
            end
`endif
        end
    endtask

    task automatic test_overflow();
        cycle(4'd15, 4'd15, 1'b1, 1'b0);
        cycle(4'd15, 4'd0,  1'b1, 1'b0);
        cycle(4'd0,  4'd0,  1'b0, 1'b0);
        cycle(4'd0,  4'd0,  1'b0, 1'b0);
        vectors++;
        if (s4 !== 4'b1111 || c4 !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_all_ones: got c=%b s=%b want c=1 s=1111", c4, s4);
        end
        cycle(4'd0, 4'd0, 1'b0, 1'b0);
        vectors++;
        if (s4 !== 4'b0000 || c4 !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_wrap: got c=%b s=%b want c=1 s=0000", c4, s4);
        end
    endtask

    task automatic test_reset_midstream();
        cycle(4'd3, 4'd9, 1'b1, 1'b1);
        cycle(4'd7, 4'd2, 1'b0, 1'b1);
        cycle(4'd11, 4'd6, 1'b1, 1'b1);
        #1 rst = 1'b1;
        #1;
        vectors++;
        if ({c4, s4} !== 5'b0 || {c16, s16} !== 17'b0 || ov4 !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_async: got %b/%b %b/%h v=%b want all 0", c4, s4, c16, s16, ov4);
        end
        rst = 1'b0;
        flush_model();
        cycle(4'd7, 4'd6, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({c4, s4} !== 5'b0 || ov4 !== 1'b0) begin
                miscompares++;
                $display("FAIL midreset_hold%0d: got c=%b s=%b v=%b want 0", i, c4, s4, ov4);
            end
            cycle(4'd0, 4'd0, 1'b0, 1'b0);
        end
        vectors++;
        if (s4 !== 4'b1110 || c4 !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_first: got c=%b s=%b want c=0 s=1110", c4, s4);
        end
`ifdef FULLY_PIPELINED_ADDER_VALID_EN
        vectors++;
        if (ov4 !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_valid: got %b want 1", ov4);
        end
`endif
    endtask

    task automatic test_random();
        for (int n = 0; n < 1000; n++) begin
            cycle(4'($urandom_range(15)), 4'($urandom_range(15)),
                  1'($urandom_range(1)), 1'($urandom_range(1)));
            vectors++;
            if ({c1, s1} !== e1[1:0]) begin
                miscompares++;
                $display("FAIL rand_w1 n=%0d: got %b%b want %b", n, c1, s1, e1[1:0]);
            end
            vectors++;
            if ({c4, s4} !== e4[4:0]) begin
                miscompares++;
                $display("FAIL rand_w4 n=%0d: got %b%b want %b", n, c4, s4, e4[4:0]);
            end
            vectors++;
            if ({c16, s16} !== e16[16:0]) begin
                miscompares++;
                $display("FAIL rand_w16 n=%0d: got %h want %h", n, {c16, s16}, e16[16:0]);
            end
`ifdef FULLY_PIPELINED_ADDER_VALID_EN
            vectors++;
            if (ov4 !== ev4) begin
                miscompares++;
                $display("FAIL rand_valid n=%0d: got %b want %b", n, ov4, ev4);
            end
`endif
        end
    endtask

    initial begin
        a1 = '0; b1 = '0; cin1 = 1'b0; v1 = 1'b0;
        a4 = '0; b4 = '0; cin4 = 1'b0; v4 = 1'b0;
        a16 = '0; b16 = '0; cin16 = 1'b0; v16 = 1'b0;
        e1 = 0; e4 = 0; e16 = 0; ev4 = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fully_pipelined_adder.md
FULLY_PIPELINED_ADDER -- requirements
Module: fully_pipelined_adder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter: WIDTH, default 4, operand/sum bit width; legal range 1..64.
REQ-003 Port: clk  input  1  clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  asynchronous active-high reset.
REQ-005 Port: a  input  WIDTH  addend A, sampled every rising edge.
REQ-006 Port: b  input  WIDTH  addend B, sampled every rising edge.
REQ-007 Port: cin  input  1  carry-in, sampled with a/b.
REQ-008 Port: s  output  WIDTH  registered sum, a+b+cin modulo 2^WIDTH.
REQ-009 Port: c  output  1  registered carry-out, bit WIDTH of a+b+cin.
REQ-010 Positional port order SHALL be s, c, a, b, cin, clk, rst.

Function
REQ-011 The adder SHALL be bit-level pipelined: WIDTH stages, stage i computes sum bit i with a 1-bit full adder from a[i], b[i] and the registered carry of stage i-1 (stage 0 uses cin).
REQ-012 Each stage SHALL register its carry-out; no combinational carry path SHALL span more than one full adder.
REQ-013 Operand bits a[i], b[i] SHALL be delayed by i register stages (input skew) so they meet the carry of the same operation.
REQ-014 Sum bit i SHALL be delayed by WIDTH-1-i register stages (output deskew) so all bits of s and c emerge together.
REQ-015 Latency: operands sampled at rising edge k SHALL appear on s and c immediately after rising edge k+WIDTH-1 (WIDTH=1: after edge k).
REQ-016 Throughput: one new operation accepted every cycle, no stalls, no backpressure; consecutive operations SHALL NOT interfere.
REQ-017 Overflow wraps: s = (a+b+cin) mod 2^WIDTH, c = (a+b+cin) >> WIDTH; all operands unsigned.
REQ-018 Outputs SHALL be driven only from flip-flops.

Reset
REQ-019 While rst=1, all pipeline registers (skew, carry, deskew) SHALL clear to 0 asynchronously; s=0, c=0.
REQ-020 Reset asserted mid-operation SHALL discard all in-flight operations; after deassertion, outputs SHALL read 0 until the first post-reset operand emerges WIDTH edges later.
REQ-021 The first rising edge with rst=0 SHALL sample operands normally.

Configuration
REQ-022 Macro FULLY_PIPELINED_ADDER_VALID_EN, when defined, SHALL add ports in_valid (input, 1) and out_valid (output, 1).
REQ-023 With the macro, in_valid SHALL travel through a WIDTH-deep valid shift register aligned with the data; out_valid SHALL be 1 exactly when s/c carry an operation sampled with in_valid=1; reset clears it to 0.
REQ-024 With the macro, data path behaviour SHALL be unchanged (s/c computed regardless of in_valid).
REQ-025 Without the macro, the ports in_valid/out_valid SHALL NOT exist and no valid logic SHALL be synthesised.

Verification
REQ-026 WIDTH=4, a=4, b=5, cin=1 at edge k -> s=1010, c=0 after edge k+3.
REQ-027 WIDTH=4, back-to-back edges k, k+1, k+2: (15,4,0), (8,8,1), (0,0,0) -> after edges k+3, k+4, k+5: s=0011 c=1; s=0001 c=1; s=0000 c=0.
REQ-028 WIDTH=4, a=15, b=15, cin=1 -> s=1111, c=1 after WIDTH edges; a=15, b=0, cin=1 -> s=0000, c=1.
REQ-029 Reset mid-stream: feed 3 operations, assert rst for a partial cycle -> s=0, c=0 immediately; after release, outputs stay 0 until new operand emerges 4 edges later.
REQ-030 WIDTH=1 and WIDTH=16 random back-to-back stream, 1000 vectors -> every output equals reference a+b+cin delayed by WIDTH-1 edges.
REQ-031 With FULLY_PIPELINED_ADDER_VALID_EN: in_valid pattern 1,0,1 at edges k..k+2 -> out_valid 1,0,1 after edges k+3..k+5 (WIDTH=4).
